night_phase_ctrl: RTL

Parametrised night-mode signal controller for the intersection light bank. It alternates right-of-way between two phase groups: phase A is the even-indexed directions (N+S), phase B is the odd-indexed directions (E+W). Switching is demand-actuated with minimum and maximum green, and every switch passes through a yellow clearance interval and an all-red interval. A flash override drives every direction to blinking yellow. It replaces the fixed 8-bit toggler and feeds the light-output mux in place of the free-running N+S/E+W inverter.

---
 rtl/night_pkg.sv | 31 +++
 rtl/dwell_timer.sv | 29 ++
 rtl/night_phase_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/night_pkg.sv
// Shared types, light codes and the phase-group direction mask for the night-mode controller.
package night_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      CLEAR  = 2'd1,
      ALLRED = 2'd2,
      FLASH  = 2'd3
   } state_t;

   localparam logic [1:0] LT_RED = 2'b00;
   localparam logic [1:0] LT_YEL = 2'b01;
   localparam logic [1:0] LT_GRN = 2'b11;

   localparam int MAX_DIRS = 32;

   // Bit d is set when direction d belongs to the group: even directions are A, odd are B.
   function automatic logic [MAX_DIRS-1:0] phase_mask(input int num_dirs, input logic ph);
      logic [MAX_DIRS-1:0] m;
      m = {MAX_DIRS{1'b0}};
      for (int d = 0; d < MAX_DIRS; d++) begin
         if ((d < num_dirs) && (d[0] == ph)) begin
            m[d] = 1'b1;
         end else begin
            m[d] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Up-counter with synchronous clear and a terminal-count compare against a supplied value.
module dwell_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] term_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;

   // Dwell count: cleared on reset or on request, otherwise counts up.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else if (clr_i) begin
         cnt_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/night_phase_ctrl.sv
// Night-mode two-group signal controller: demand-actuated greens with yellow and all-red
// clearance between every switch, plus a blinking-yellow flash override.
module night_phase_ctrl
   import night_pkg::*;
#(
   parameter int NUM_DIRS    = 4,
   parameter int MIN_GREEN   = 4,
   parameter int MAX_GREEN   = 12,
   parameter int CLEAR_CYC   = 2,
   parameter int ALL_RED_CYC = 1,
   parameter int FLASH_HALF  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  demandA,
   input  logic                  demandB,
   input  logic                  flash,
   output logic [2*NUM_DIRS-1:0] laneOutput,
   output logic                  phase,
   output logic                  busy
);

   localparam int CMAX_A = (MAX_GREEN > CLEAR_CYC) ? MAX_GREEN : CLEAR_CYC;
   localparam int CMAX_B = (ALL_RED_CYC > FLASH_HALF) ? ALL_RED_CYC : FLASH_HALF;
   localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
   localparam int CW     = $clog2(CMAX + 1);

   localparam logic [CW-1:0] T_MIN    = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] T_GREEN  = CW'(MAX_GREEN - 1);
   localparam logic [CW-1:0] T_CLEAR  = CW'(CLEAR_CYC - 1);
   localparam logic [CW-1:0] T_ALLRED = CW'(ALL_RED_CYC - 1);
   localparam logic [CW-1:0] T_FLASH  = CW'(FLASH_HALF - 1);

   // Light pattern for a given state, right-of-way group and flash phase.
   function automatic logic [2*NUM_DIRS-1:0] decode_lanes(input state_t st, input logic ph,
                                                          input logic fb);
      logic [NUM_DIRS-1:0]   mask;
      logic [2*NUM_DIRS-1:0] lanes;
      mask  = NUM_DIRS'(phase_mask(NUM_DIRS, ph));
      lanes = {(2*NUM_DIRS){1'b0}};
      for (int d = 0; d < NUM_DIRS; d++) begin
         case (st)
            GREEN:   lanes[2*d +: 2] = mask[d] ? LT_GRN : LT_RED;
            CLEAR:   lanes[2*d +: 2] = mask[d] ? LT_YEL : LT_RED;
            ALLRED:  lanes[2*d +: 2] = LT_RED;
            FLASH:   lanes[2*d +: 2] = fb ? LT_YEL : LT_RED;
            default: lanes[2*d +: 2] = LT_RED;
         endcase
      end
      return lanes;
   endfunction

   state_t                state_q, state_d;
   logic                  phase_q, phase_d;
   logic                  fbit_q, fbit_d;
   logic [2*NUM_DIRS-1:0] lane_q, lane_d;
   logic                  busy_q, busy_d;

   logic [CW-1:0] cnt_s;
   logic [CW-1:0] term_s;
   logic          tc_s;
   logic          clr_s;
   logic          opp_s;

   assign opp_s = phase_q ? demandA : demandB;

   // Terminal count for the dwell of the current state.
   always_comb begin
      term_s = T_GREEN;
      case (state_q)
         GREEN:   term_s = T_GREEN;
         CLEAR:   term_s = T_CLEAR;
         ALLRED:  term_s = T_ALLRED;
         FLASH:   term_s = T_FLASH;
         default: term_s = T_GREEN;
      endcase
   end

   // Next-state logic; flash overrides every state without clearance.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      fbit_d  = fbit_q;
      if (flash && (state_q != FLASH)) begin
         state_d = FLASH;
         fbit_d  = 1'b1;
      end else begin
         case (state_q)
            GREEN: begin
               if (((cnt_s >= T_MIN) && opp_s) || tc_s) begin
                  state_d = CLEAR;
               end else begin
                  state_d = GREEN;
               end
            end
            CLEAR: begin
               if (tc_s) begin
                  state_d = ALLRED;
                  phase_d = ~phase_q;
               end else begin
                  state_d = CLEAR;
               end
            end
            ALLRED: begin
               if (tc_s) begin
                  state_d = GREEN;
               end else begin
                  state_d = ALLRED;
               end
            end
            FLASH: begin
               // Leaving flash always hands right-of-way to group B after an all-red.
               if (!flash) begin
                  state_d = ALLRED;
                  phase_d = 1'b1;
               end else if (tc_s) begin
                  fbit_d = ~fbit_q;
               end else begin
                  fbit_d = fbit_q;
               end
            end
            default: begin
               state_d = GREEN;
            end
         endcase
      end
   end

   assign clr_s  = (state_d != state_q) || tc_s;
   assign lane_d = decode_lanes(state_d, phase_d, fbit_d);
   assign busy_d = (state_d == CLEAR) || (state_d == ALLRED);

   dwell_timer #(
      .WIDTH (CW)
   ) u_dwell (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr_s),
      .term_i (term_s),
      .cnt_o  (cnt_s),
      .tc_o   (tc_s)
   );

   // State, phase, flash bit and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GREEN;
         phase_q <= 1'b1;
         fbit_q  <= 1'b1;
         lane_q  <= decode_lanes(GREEN, 1'b1, 1'b1);
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         fbit_q  <= fbit_d;
         lane_q  <= lane_d;
         busy_q  <= busy_d;
      end
   end

   assign laneOutput = lane_q;
   assign phase      = phase_q;
   assign busy       = busy_q;

endmodule
